// File: rtl/output_last.sv
// Output repacker: normalized sign/exp/mantissa to FP16 or signed fixed-point.
// Two-stage valid/ready pipeline with rounding, saturation and a sat counter.
module output_last #(
  parameter int width_out      = 16,
  parameter int width_exp      = 5,
  parameter int width_mantissa = 10,
  parameter int width_cnt      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [width_exp-1:0]      in_exp,
  input  logic [width_mantissa-1:0] in_mantissa,
  input  logic                      in_zero_flag,
  input  logic                      type_sel,
  input  logic [width_exp-1:0]      n,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [width_out-1:0]      outdata,
  output logic                      out_sat,
  input  logic                      cnt_clr,
  output logic [width_cnt-1:0]      sat_cnt
);

  localparam int MW   = width_mantissa + 1;
  localparam int KSAT = width_out - MW;
  localparam int KMIN = -MW;
  localparam int SW   = $clog2(MW + 1);

  logic                      s1_valid;
  logic                      s1_sign;
  logic [width_exp-1:0]      s1_exp;
  logic [width_mantissa-1:0] s1_man;
  logic                      s1_zero;
  logic                      s1_type;
  logic signed [6:0]         s1_k;

  logic                      out_load;
  logic signed [6:0]         k_in;

  assign out_load = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | out_load;
  assign k_in     = 7'(in_exp) + 7'(n) - 7'sd25;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_zero  <= 1'b0;
      s1_type  <= 1'b0;
      s1_k     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_man  <= in_mantissa;
        s1_zero <= in_zero_flag;
        s1_type <= type_sel;
        s1_k    <= k_in;
      end
    end
  end

  logic [MW-1:0]        m_full;
  logic [MW:0]          rnd;
  logic [SW-1:0]        sh;
  logic [width_out-1:0] mag;
  logic [width_out-1:0] res;
  logic                 res_sat;

  assign m_full = {1'b1, s1_man};

  always_comb begin
    rnd     = '0;
    sh      = '0;
    mag     = '0;
    res     = '0;
    res_sat = 1'b0;
    if (s1_type) begin
      if (s1_zero || s1_exp == '0) begin
        res = {s1_sign, {(width_out-1){1'b0}}};
      end else if (&s1_exp) begin
        res     = {s1_sign, {(width_exp-1){1'b1}}, 1'b0,
                   {width_mantissa{1'b1}}};
        res_sat = 1'b1;
      end else begin
        res = {s1_sign, s1_exp, s1_man};
      end
    end else if (!s1_zero) begin
      if (int'(s1_k) >= KSAT) begin
        res_sat = 1'b1;
        res     = s1_sign ? {1'b1, {(width_out-1){1'b0}}}
                          : {1'b0, {(width_out-1){1'b1}}};
      end else begin
        if (int'(s1_k) >= 0) begin
          mag = width_out'(m_full) << s1_k[3:0];
        end else if (int'(s1_k) >= KMIN) begin
          // add half an LSB of the result, then truncate
          sh  = SW'(-s1_k);
          rnd = {1'b0, m_full} + ((MW+1)'(1) << (sh - SW'(1)));
          mag = width_out'(rnd >> sh);
        end
        res = s1_sign ? (~mag + width_out'(1)) : mag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      outdata   <= '0;
      out_sat   <= 1'b0;
    end else if (out_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        outdata <= res;
        out_sat <= res_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + width_cnt'(1);
    end
  end

endmodule

// File: tb/tb_output_last.sv
// Directed self-checking bench for output_last.
// Covers FP16/fixed packing, rounding, saturation, backpressure, reset.
module tb_output_last;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [9:0]  in_mantissa;
  logic        in_zero_flag;
  logic        type_sel;
  logic [4:0]  n;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] outdata;
  logic        out_sat;
  logic        cnt_clr;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_last dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mantissa(in_mantissa), .in_zero_flag(in_zero_flag),
    .type_sel(type_sel), .n(n),
    .out_valid(out_valid), .out_ready(out_ready),
    .outdata(outdata), .out_sat(out_sat),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic s, input logic [4:0] e,
                      input logic [9:0] m, input logic z,
                      input logic t, input logic [4:0] nn);
    in_sign      = s;
    in_exp       = e;
    in_mantissa  = m;
    in_zero_flag = z;
    type_sel     = t;
    n            = nn;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one beat with out_ready high, checked two edges after acceptance
  task automatic send(input string tag, input logic s, input logic [4:0] e,
                      input logic [9:0] m, input logic z, input logic t,
                      input logic [4:0] nn, input logic [15:0] exp_d,
                      input logic exp_s);
    beat(s, e, m, z, t, nn);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat"}, {15'd0, out_valid}, 16'd0);
    tick();
    chk({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
    chk(tag, outdata, exp_d);
    chk({tag, "_sat"}, {15'd0, out_sat}, {15'd0, exp_s});
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    beat(1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_data", outdata, 16'h0000);
    chk("rst_sat", {15'd0, out_sat}, 16'd0);
    chk("rst_cnt", sat_cnt, 16'd0);
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    #12 rst = 1'b1;
    tick();

    send("fp_pass", 0, 5'd15, 10'h200, 0, 1, 5'd0, 16'h3E00, 0);
    send("fp_inf", 0, 5'd31, 10'h000, 0, 1, 5'd0, 16'h7BFF, 1);
    tick();
    chk("cnt_fp", sat_cnt, 16'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", sat_cnt, 16'd0);

    send("fx_3p0", 0, 5'd16, 10'h200, 0, 0, 5'd4, 16'h0030, 0);
    send("fx_m3p0", 1, 5'd16, 10'h200, 0, 0, 5'd4, 16'hFFD0, 0);
    send("fx_half", 0, 5'd14, 10'h000, 0, 0, 5'd0, 16'h0001, 0);
    send("fx_mhalf", 1, 5'd14, 10'h000, 0, 0, 5'd0, 16'hFFFF, 0);
    send("fx_tiny", 0, 5'd13, 10'h000, 0, 0, 5'd0, 16'h0000, 0);
    send("fx_mtiny", 1, 5'd13, 10'h000, 0, 0, 5'd0, 16'h0000, 0);
    send("fx_zero", 1, 5'd20, 10'h155, 1, 0, 5'd3, 16'h0000, 0);
    send("fx_k0", 0, 5'd20, 10'h000, 0, 0, 5'd5, 16'h0400, 0);
    send("fx_k4", 0, 5'd24, 10'h3FF, 0, 0, 5'd5, 16'h7FF0, 0);
    send("fx_mk4", 1, 5'd24, 10'h000, 0, 0, 5'd5, 16'hC000, 0);
    send("fp_denorm", 1, 5'd0, 10'h123, 0, 1, 5'd0, 16'h8000, 0);
    send("fp_zero", 0, 5'd20, 10'h123, 1, 1, 5'd0, 16'h0000, 0);

    send("fx_satp", 0, 5'd30, 10'h000, 0, 0, 5'd0, 16'h7FFF, 1);
    send("fx_satn", 1, 5'd30, 10'h000, 0, 0, 5'd0, 16'h8000, 1);
    tick();
    chk("cnt_two", sat_cnt, 16'd2);
    send("fx_sat3", 0, 5'd31, 10'h3FF, 0, 0, 5'd31, 16'h7FFF, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_pri", sat_cnt, 16'd0);
    tick();
    chk("cnt_after", sat_cnt, 16'd0);

    // backpressure: A, B buffered, C waits
    out_ready = 1'b0;
    beat(0, 5'd16, 10'h200, 0, 0, 5'd4);
    in_valid = 1'b1;
    tick();
    beat(0, 5'd15, 10'h200, 0, 1, 5'd0);
    tick();
    chk("bp_a", outdata, 16'h0030);
    chk("bp_full", {15'd0, in_ready}, 16'd0);
    beat(1, 5'd14, 10'h000, 0, 0, 5'd0);
    tick();
    tick();
    chk("bp_a_hold", outdata, 16'h0030);
    chk("bp_vhold", {15'd0, out_valid}, 16'd1);
    chk("bp_full2", {15'd0, in_ready}, 16'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_comb", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_b", outdata, 16'h3E00);
    tick();
    chk("bp_c", outdata, 16'hFFFF);
    chk("bp_cv", {15'd0, out_valid}, 16'd1);
    tick();
    chk("bp_end", {15'd0, out_valid}, 16'd0);

    // reset with two beats buffered
    send("pre_rst", 1, 5'd30, 10'h000, 0, 0, 5'd0, 16'h8000, 1);
    tick();
    chk("pre_rst_cnt", sat_cnt, 16'd1);
    out_ready = 1'b0;
    beat(0, 5'd16, 10'h200, 0, 0, 5'd4);
    in_valid = 1'b1;
    tick();
    beat(0, 5'd15, 10'h200, 0, 1, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("mid_full", {15'd0, in_ready}, 16'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_data", outdata, 16'h0000);
    chk("mid_cnt", sat_cnt, 16'd0);
    chk("mid_ready", {15'd0, in_ready}, 16'd1);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    send("post_rst", 1, 5'd16, 10'h200, 0, 0, 5'd4, 16'hFFD0, 0);
    tick();
    chk("post_drain", {15'd0, out_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
